// File: rtl/bus_cycle_control_pkg.sv
// Shared constants for the bus cycle controller: device one-hot positions,
// port width codes, FSM state encodings and DSACK encodings.
package bus_cycle_control_pkg;

    // One-hot bit positions of device_selected; all-zero means DEVICE_NULL.
    localparam int DEVICE_SELECTED_MAXPOS = 10;
    localparam int DEVICE_ROM   = 0;
    localparam int DEVICE_FPGA  = 1;
    localparam int DEVICE_QUART = 2;
    localparam int DEVICE_SLOT0 = 3;
    localparam int DEVICE_SLOT1 = 4;
    localparam int DEVICE_SLOT2 = 5;
    localparam int DEVICE_SLOT3 = 6;
    localparam int DEVICE_IDE1  = 7;
    localparam int DEVICE_IDE3  = 8;
    localparam int DEVICE_ETH   = 9;
    localparam logic [DEVICE_SELECTED_MAXPOS-1:0] DEVICE_NULL = '0;

    localparam int PORT_WIDTH_WIDTH = 2;
    localparam logic [PORT_WIDTH_WIDTH-1:0] PORT_WIDTH_NULL = 2'd0;
    localparam logic [PORT_WIDTH_WIDTH-1:0] PORT_WIDTH_BYTE = 2'd1;
    localparam logic [PORT_WIDTH_WIDTH-1:0] PORT_WIDTH_WORD = 2'd2;
    localparam logic [PORT_WIDTH_WIDTH-1:0] PORT_WIDTH_LONG = 2'd3;

    // Wide enough for any per-device wait count.
    localparam int WAIT_WIDTH = 4;

    typedef enum logic [1:0] {
        BUS_STATE_IDLE = 2'd0,
        BUS_STATE_WAIT = 2'd1,
        BUS_STATE_ACK  = 2'd2,
        BUS_STATE_BERR = 2'd3
    } bus_state_e;

    // {DSACK1,DSACK0}
    localparam logic [1:0] DSACK_NONE = 2'b00;
    localparam logic [1:0] DSACK_BYTE = 2'b01;
    localparam logic [1:0] DSACK_WORD = 2'b10;
    localparam logic [1:0] DSACK_LONG = 2'b11;

    function automatic logic [1:0] dsack_from_width(input logic [PORT_WIDTH_WIDTH-1:0] width);
        case (width)
            PORT_WIDTH_BYTE: dsack_from_width = DSACK_BYTE;
            PORT_WIDTH_WORD: dsack_from_width = DSACK_WORD;
            PORT_WIDTH_LONG: dsack_from_width = DSACK_LONG;
            default:         dsack_from_width = DSACK_NONE;
        endcase
    endfunction

endpackage

// File: rtl/bus_cycle_control_wait_lookup.sv
// Combinational device -> wait-state count and slot-class flag.
// Slot-class devices may stretch the cycle further with ext_wait.
module bus_cycle_control_wait_lookup
    import bus_cycle_control_pkg::*;
#(
    parameter int ROM_WAIT  = 2,
    parameter int SLOT_WAIT = 1,
    parameter int IO_WAIT   = 3,
    parameter int FPGA_WAIT = 0
) (
    input  logic [DEVICE_SELECTED_MAXPOS-1:0] device_selected_i,
    output logic [WAIT_WIDTH-1:0]             wait_count_o,
    output logic                              slot_class_o
);

    logic slot_hit;
    assign slot_hit = device_selected_i[DEVICE_SLOT0] | device_selected_i[DEVICE_SLOT1] |
                      device_selected_i[DEVICE_SLOT2] | device_selected_i[DEVICE_SLOT3] |
                      device_selected_i[DEVICE_IDE1]  | device_selected_i[DEVICE_IDE3]  |
                      device_selected_i[DEVICE_ETH];

    // Table lookup; NULL yields zero wait and is diverted to BERR by the FSM.
    always_comb begin
        wait_count_o = '0;
        slot_class_o = 1'b0;
        if (device_selected_i[DEVICE_ROM]) begin
            wait_count_o = WAIT_WIDTH'(ROM_WAIT);
        end else if (device_selected_i[DEVICE_FPGA]) begin
            wait_count_o = WAIT_WIDTH'(FPGA_WAIT);
        end else if (device_selected_i[DEVICE_QUART]) begin
            wait_count_o = WAIT_WIDTH'(IO_WAIT);
        end else if (slot_hit) begin
            wait_count_o = WAIT_WIDTH'(SLOT_WAIT);
            slot_class_o = 1'b1;
        end
    end

endmodule

// File: rtl/bus_cycle_control.sv
// 68030 asynchronous bus cycle controller: per-device wait states, DSACK
// port-size encoding, slot wait stretching, BERR on decode miss, and the
// vector_fetched flag used for the reset-vector ROM overlay.
// Optional watchdog: define BUS_TIMEOUT_EN to turn a WAIT state that lasts
// TIMEOUT_CYCLES clocks into a bus error.
module bus_cycle_control
    import bus_cycle_control_pkg::*;
#(
    parameter int ROM_WAIT       = 2,
    parameter int SLOT_WAIT      = 1,
    parameter int IO_WAIT        = 3,
    parameter int FPGA_WAIT      = 0,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int VECTOR_CYCLES  = 4
) (
    input  logic                              clock_i,
    input  logic                              reset_i,
    input  logic                              as_i,
    input  logic                              function_normal_selected_i,
    input  logic [DEVICE_SELECTED_MAXPOS-1:0] device_selected_i,
    input  logic [PORT_WIDTH_WIDTH-1:0]       port_width_i,
    input  logic                              ext_wait_i,
    output logic [1:0]                        dsack_o,
    output logic                              berr_o,
    output logic                              cycle_active_o,
    output logic                              vector_fetched_o
);

    localparam int VEC_W = $clog2(VECTOR_CYCLES + 1);

    bus_state_e                  state_q;
    logic [WAIT_WIDTH-1:0]       wait_cnt_q;
    logic                        slot_q;
    logic [PORT_WIDTH_WIDTH-1:0] width_q;
    logic [VEC_W-1:0]            vec_cnt_q;
    logic [1:0]                  dsack_q;
    logic                        berr_q;
    logic                        cycle_active_q;
    logic                        vector_fetched_q;

    logic [WAIT_WIDTH-1:0]       lookup_wait;
    logic                        lookup_slot;
    logic                        timeout_hit;

    bus_cycle_control_wait_lookup #(
        .ROM_WAIT  (ROM_WAIT),
        .SLOT_WAIT (SLOT_WAIT),
        .IO_WAIT   (IO_WAIT),
        .FPGA_WAIT (FPGA_WAIT)
    ) u_wait_lookup (
        .device_selected_i (device_selected_i),
        .wait_count_o      (lookup_wait),
        .slot_class_o      (lookup_slot)
    );

`ifdef BUS_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] wd_cnt_q;

    // Watchdog counts WAIT clocks; fires on the clock that would reach the limit.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            wd_cnt_q <= '0;
        end else if (state_q != BUS_STATE_WAIT) begin
            wd_cnt_q <= '0;
        end else begin
            wd_cnt_q <= wd_cnt_q + 1'b1;
        end
    end
    assign timeout_hit = (wd_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // Bus handshake FSM with registered strobes and the vector fetch counter.
    // The wait counter is "done" on the clock it reaches zero, so a count of
    // N > 0 spends N clocks in WAIT and a count of 0 spends one.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q          <= BUS_STATE_IDLE;
            wait_cnt_q       <= '0;
            slot_q           <= 1'b0;
            width_q          <= PORT_WIDTH_NULL;
            vec_cnt_q        <= '0;
            dsack_q          <= DSACK_NONE;
            berr_q           <= 1'b0;
            cycle_active_q   <= 1'b0;
            vector_fetched_q <= 1'b0;
        end else begin
            case (state_q)
                BUS_STATE_IDLE: begin
                    if (as_i && function_normal_selected_i) begin
                        cycle_active_q <= 1'b1;
                        if (device_selected_i == DEVICE_NULL) begin
                            state_q <= BUS_STATE_BERR;
                            berr_q  <= 1'b1;
                        end else begin
                            state_q    <= BUS_STATE_WAIT;
                            wait_cnt_q <= lookup_wait;
                            slot_q     <= lookup_slot;
                            width_q    <= port_width_i;
                        end
                    end
                end
                BUS_STATE_WAIT: begin
                    if (!as_i) begin
                        state_q        <= BUS_STATE_IDLE;
                        wait_cnt_q     <= '0;
                        cycle_active_q <= 1'b0;
                    end else if (timeout_hit) begin
                        state_q <= BUS_STATE_BERR;
                        berr_q  <= 1'b1;
                    end else if (wait_cnt_q > WAIT_WIDTH'(1)) begin
                        wait_cnt_q <= wait_cnt_q - 1'b1;
                    end else begin
                        wait_cnt_q <= '0;
                        if (slot_q && ext_wait_i) begin
                            state_q <= BUS_STATE_WAIT;
                        end else if (width_q == PORT_WIDTH_NULL) begin
                            state_q <= BUS_STATE_BERR;
                            berr_q  <= 1'b1;
                        end else begin
                            state_q <= BUS_STATE_ACK;
                            dsack_q <= dsack_from_width(width_q);
                        end
                    end
                end
                BUS_STATE_ACK: begin
                    if (!as_i) begin
                        state_q        <= BUS_STATE_IDLE;
                        dsack_q        <= DSACK_NONE;
                        cycle_active_q <= 1'b0;
                        if (!vector_fetched_q) begin
                            vec_cnt_q <= vec_cnt_q + 1'b1;
                            if (vec_cnt_q == VEC_W'(VECTOR_CYCLES - 1)) begin
                                vector_fetched_q <= 1'b1;
                            end
                        end
                    end
                end
                BUS_STATE_BERR: begin
                    if (!as_i) begin
                        state_q        <= BUS_STATE_IDLE;
                        berr_q         <= 1'b0;
                        cycle_active_q <= 1'b0;
                    end
                end
                default: state_q <= BUS_STATE_IDLE;
            endcase
        end
    end

    assign dsack_o          = dsack_q;
    assign berr_o           = berr_q;
    assign cycle_active_o   = cycle_active_q;
    assign vector_fetched_o = vector_fetched_q;

endmodule

// File: tb/tb_bus_cycle_control.sv
// Directed bench for bus_cycle_control; inputs change and outputs are
// sampled 1 time unit after each rising clock edge.
module tb_bus_cycle_control;
    import bus_cycle_control_pkg::*;

    logic                              clk;
    logic                              rst;
    logic                              as_s;
    logic                              fn_norm;
    logic [DEVICE_SELECTED_MAXPOS-1:0] dev;
    logic [PORT_WIDTH_WIDTH-1:0]       pw;
    logic                              ext_wait;
    logic [1:0]                        dsack;
    logic                              berr;
    logic                              cyc_act;
    logic                              vec_f;

    int n_checks = 0;
    int n_errors = 0;

    bus_cycle_control #(.TIMEOUT_CYCLES(16)) dut (
        .clock_i                    (clk),
        .reset_i                    (rst),
        .as_i                       (as_s),
        .function_normal_selected_i (fn_norm),
        .device_selected_i          (dev),
        .port_width_i               (pw),
        .ext_wait_i                 (ext_wait),
        .dsack_o                    (dsack),
        .berr_o                     (berr),
        .cycle_active_o             (cyc_act),
        .vector_fetched_o           (vec_f)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DEVICE_SELECTED_MAXPOS-1:0] onehot(input int pos);
        logic [DEVICE_SELECTED_MAXPOS-1:0] v;
        v = '0;
        v[pos] = 1'b1;
        return v;
    endfunction

    // Full cycle: dsack must stay 00 until clock n_ack after as, then show exp_ds.
    task automatic run_cycle(input string tag, input int dpos, input logic [1:0] width,
                             input int n_ack, input logic [1:0] exp_ds, input logic exp_vf);
        dev = onehot(dpos);
        pw = width;
        as_s = 1'b1;
        for (int k = 1; k <= n_ack; k++) begin
            tick();
            if (k < n_ack) check({tag, " pre-ack dsack"}, 8'(dsack), 8'h00);
            else           check({tag, " ack dsack"}, 8'(dsack), 8'(exp_ds));
        end
        as_s = 1'b0;
        tick();
        check({tag, " release dsack"}, 8'(dsack), 8'h00);
        check({tag, " vector_fetched"}, 8'(vec_f), 8'(exp_vf));
    endtask

    initial begin
        logic seen_berr;
        rst = 1'b1; as_s = 1'b0; fn_norm = 1'b1; dev = '0; pw = PORT_WIDTH_NULL; ext_wait = 1'b0;
        tick(); tick();
        check("reset dsack", 8'(dsack), 8'h00);
        check("reset berr", 8'(berr), 8'h00);
        check("reset cycle_active", 8'(cyc_act), 8'h00);
        check("reset vector_fetched", 8'(vec_f), 8'h00);
        rst = 1'b0;
        tick();

        // Four ROM word cycles; cycle 2 changes decode mid-cycle, which must be ignored.
        for (int c = 0; c < 4; c++) begin
            dev = onehot(DEVICE_ROM); pw = PORT_WIDTH_WORD; as_s = 1'b1;
            tick();
            check("rom wait cycle_active", 8'(cyc_act), 8'h01);
            check("rom clk1 dsack", 8'(dsack), 8'h00);
            if (c == 1) begin dev = onehot(DEVICE_FPGA); pw = PORT_WIDTH_BYTE; end
            tick();
            check("rom clk2 dsack", 8'(dsack), 8'h00);
            tick();
            check("rom clk3 dsack", 8'(dsack), 8'(DSACK_WORD));
            tick();
            check("rom hold dsack", 8'(dsack), 8'(DSACK_WORD));
            check("rom vf before release", 8'(vec_f), 8'h00);
            as_s = 1'b0;
            tick();
            check("rom release dsack", 8'(dsack), 8'h00);
            check("rom vector_fetched", 8'(vec_f), (c == 3) ? 8'h01 : 8'h00);
        end

        // FPGA byte cycle, zero wait: dsack on clock 2, held, cleared on release.
        dev = onehot(DEVICE_FPGA); pw = PORT_WIDTH_BYTE; as_s = 1'b1;
        tick(); check("fpga clk1 dsack", 8'(dsack), 8'h00);
        tick(); check("fpga clk2 dsack", 8'(dsack), 8'(DSACK_BYTE));
        tick(); tick(); check("fpga hold dsack", 8'(dsack), 8'(DSACK_BYTE));
        as_s = 1'b0;
        tick(); check("fpga release dsack", 8'(dsack), 8'h00);
        check("fpga release cycle_active", 8'(cyc_act), 8'h00);

        // QUART long cycle, wait 3: dsack on clock 4.
        run_cycle("quart", DEVICE_QUART, PORT_WIDTH_LONG, 4, DSACK_LONG, 1'b1);

        // Decode miss: berr next clock, never with dsack.
        dev = DEVICE_NULL; pw = PORT_WIDTH_WORD; as_s = 1'b1;
        tick(); check("null berr", 8'(berr), 8'h01);
        check("null dsack", 8'(dsack), 8'h00);
        tick(); check("null berr hold", 8'(berr), 8'h01);
        as_s = 1'b0;
        tick(); check("null berr release", 8'(berr), 8'h00);

        // Non-normal function space is ignored.
        fn_norm = 1'b0; dev = onehot(DEVICE_ROM); pw = PORT_WIDTH_WORD; as_s = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        check("fn ignore dsack", 8'(dsack), 8'h00);
        check("fn ignore cycle_active", 8'(cyc_act), 8'h00);
        as_s = 1'b0; fn_norm = 1'b1;
        tick();

        // Device with NULL port width goes to BERR after its wait.
        dev = onehot(DEVICE_FPGA); pw = PORT_WIDTH_NULL; as_s = 1'b1;
        tick(); check("nullwidth clk1 berr", 8'(berr), 8'h00);
        tick(); check("nullwidth clk2 berr", 8'(berr), 8'h01);
        check("nullwidth clk2 dsack", 8'(dsack), 8'h00);
        as_s = 1'b0;
        tick(); check("nullwidth release berr", 8'(berr), 8'h00);

        // SLOT1 with ext_wait held for 10 clocks.
        dev = onehot(DEVICE_SLOT1); pw = PORT_WIDTH_WORD; ext_wait = 1'b1; as_s = 1'b1;
        for (int k = 0; k < 10; k++) tick();
        check("slot held dsack", 8'(dsack), 8'h00);
        check("slot held cycle_active", 8'(cyc_act), 8'h01);
        ext_wait = 1'b0;
        tick(); check("slot ext_wait fall dsack", 8'(dsack), 8'(DSACK_WORD));
        as_s = 1'b0;
        tick(); check("slot release dsack", 8'(dsack), 8'h00);

        // Aborted cycle: as drops in WAIT.
        dev = onehot(DEVICE_ROM); pw = PORT_WIDTH_WORD; as_s = 1'b1;
        tick();
        as_s = 1'b0;
        tick(); check("abort cycle_active", 8'(cyc_act), 8'h00);
        tick(); tick(); check("abort dsack", 8'(dsack), 8'h00);
        run_cycle("after abort", DEVICE_ROM, PORT_WIDTH_WORD, 3, DSACK_WORD, 1'b1);

        // Stuck ext_wait.
        dev = onehot(DEVICE_SLOT0); pw = PORT_WIDTH_WORD; ext_wait = 1'b1; as_s = 1'b1;
`ifdef BUS_TIMEOUT_EN
        for (int k = 0; k < 16; k++) tick();
        check("timeout before limit berr", 8'(berr), 8'h00);
        tick();
        check("timeout berr", 8'(berr), 8'h01);
        check("timeout dsack", 8'(dsack), 8'h00);
`else
        seen_berr = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            tick();
            if (berr || dsack != 2'b00) seen_berr = 1'b1;
        end
        check("stuck no berr/dsack", 8'(seen_berr), 8'h00);
        check("stuck cycle_active", 8'(cyc_act), 8'h01);
`endif
        ext_wait = 1'b0; as_s = 1'b0;
        tick(); tick();

        // Asynchronous reset during ACK.
        dev = onehot(DEVICE_FPGA); pw = PORT_WIDTH_WORD; as_s = 1'b1;
        tick(); tick();
        check("pre-reset dsack", 8'(dsack), 8'(DSACK_WORD));
        #2 rst = 1'b1;
        #1;
        check("async reset dsack", 8'(dsack), 8'h00);
        check("async reset vector_fetched", 8'(vec_f), 8'h00);
        check("async reset cycle_active", 8'(cyc_act), 8'h00);
        as_s = 1'b0;
        tick();
        rst = 1'b0;
        tick();

        // BERR cycles do not count toward the vector fetch.
        for (int c = 0; c < 3; c++) run_cycle("recount", DEVICE_ROM, PORT_WIDTH_WORD, 3, DSACK_WORD, 1'b0);
        dev = DEVICE_NULL; as_s = 1'b1;
        tick(); as_s = 1'b0; tick();
        check("berr not counted vf", 8'(vec_f), 8'h00);
        run_cycle("recount last", DEVICE_ROM, PORT_WIDTH_WORD, 3, DSACK_WORD, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/bus_cycle_control.md
Name: bus_cycle_control

Overview:
- Sits directly downstream of device_decode and consumes its device_selected and port_width outputs.
- Runs the 68030 asynchronous bus handshake: asserts DSACK with the correct port-size encoding after per-device wait states, stretches for slot-card wait requests, and asserts BERR on decode misses.
- Also generates vector_fetched, which device_decode takes as an input (ROM overlay for the reset vector fetch).
- All bus strobes are internal active-high; pad inversion happens at the top level.

Parameters:
- ROM_WAIT, 2, wait cycles before DSACK for DEVICE_ROM
- SLOT_WAIT, 1, minimum wait cycles for DEVICE_SLOT0..3, DEVICE_IDE1, DEVICE_IDE3, DEVICE_ETH
- IO_WAIT, 3, wait cycles for DEVICE_QUART
- FPGA_WAIT, 0, wait cycles for DEVICE_FPGA
- VECTOR_CYCLES, 4, completed cycles before vector_fetched rises (SSP + PC, 2 longs as 4 word cycles)
- TIMEOUT_CYCLES, 255, watchdog limit (only with BUS_TIMEOUT_EN)

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- as  in  1  address strobe, synchronised, active-high
- function_normal_selected  in  1  from function_decode
- device_selected  in  DEVICE_SELECTED_MAXPOS  one-hot from device_decode; all-zero = DEVICE_NULL
- port_width  in  PORT_WIDTH_WIDTH  from device_decode
- ext_wait  in  1  slot/IDE/ETH request to extend the cycle, active-high
- dsack  out  2  {DSACK1,DSACK0}, active-high
- berr  out  1  bus error, active-high
- cycle_active  out  1  high while a cycle is being serviced
- vector_fetched  out  1  low after reset until VECTOR_CYCLES normal cycles have completed

Behaviour:
- Reset values: dsack = 2'b00, berr = 0, cycle_active = 0, vector_fetched = 0, wait counter = 0, vector counter = 0, state = IDLE.
- States and transitions:
  - IDLE: on as=1 with function_normal_selected=1:
    - device_selected == NULL → BERR.
    - otherwise load the wait counter from the table for the one-hot device → WAIT.
  - IDLE: as=1 with function_normal_selected=0 (FPU, INT_ACK) is ignored; stay IDLE.
  - WAIT: cycle_active=1.
    - Counter decrements each clock.
    - At zero, if the device is a slot-class device and ext_wait=1, hold.
    - Otherwise → ACK.
  - ACK: dsack set from port_width.
    - BYTE = 2'b01, WORD = 2'b10, LONG = 2'b11, NULL = 2'b00 (NULL forces BERR instead).
    - dsack is held until as=0, then → IDLE with dsack cleared in the same clock edge.
  - BERR: berr=1 and dsack=00, held until as=0, then → IDLE.
- Latency: first clock after as is sampled high is IDLE→WAIT. A wait value of 0 gives dsack asserted on the 2nd clock after as.
- as dropping in WAIT (aborted cycle): → IDLE next clock, no dsack, no counter side effects.
- dsack and berr are never asserted together.
- device_selected and port_width are sampled once on IDLE→WAIT. Later changes inside the cycle are ignored.
- Vector counter:
  - Increments on each ACK→IDLE exit while vector_fetched=0.
  - vector_fetched rises on the clock the count reaches VECTOR_CYCLES, then sticks high until reset.
  - BERR cycles do not count.
- Asynchronous reset mid-cycle forces reset values immediately, including dropping dsack.

Optional Feature:
- Macro: BUS_TIMEOUT_EN.
- Defined:
  - A watchdog counter runs in WAIT. Width is the minimum needed to hold TIMEOUT_CYCLES.
  - It clears on entry to WAIT.
  - If it reaches TIMEOUT_CYCLES while still in WAIT (e.g. ext_wait stuck), go → BERR.
- Not defined: no watchdog. A stuck ext_wait holds WAIT indefinitely. Decode-miss BERR is still present.

Decomposition:
- Shared package addr_decode.vh already holds the DEVICE_*, PORT_WIDTH_*, FUNCTION_* and *_MAXPOS constants.
- Add to it:
  - state encodings BUS_STATE_IDLE/WAIT/ACK/BERR
  - DSACK_BYTE/WORD/LONG/NONE constants
- Natural sub-module: bus_wait_lookup, a combinational device_selected → wait count and slot-class flag.

Test Plan:
- After reset, 4 cycles with DEVICE_ROM and PORT_WIDTH_WORD, each with ROM_WAIT=2 → dsack=10 on the 3rd clock after as in each cycle. vector_fetched goes 0→1 after the 4th as deassert and stays 1.
- FPGA byte cycle, FPGA_WAIT=0 → dsack=01 on the 2nd clock after as, held until as=0, cleared on the next edge.
- as=1 with normal function and DEVICE_NULL → berr=1 on the next clock, dsack=00, berr clears after as=0. vector counter unchanged.
- SLOT1 cycle with ext_wait held 10 clocks → dsack=10 exactly 1 clock after ext_wait falls. Also: as dropped mid-WAIT → no dsack.
- BUS_TIMEOUT_EN, TIMEOUT_CYCLES=16, ext_wait stuck high → berr after 16 WAIT clocks. Same stimulus without the macro → no berr after 1000 clocks.
- reset asserted during ACK → dsack=00 without waiting for a clock edge. vector_fetched returns to 0.
